posit_noncomp_arb: RTL and testbench
====================================

POSIT_NONCOMP_ARB -- requirements
Module: posit_noncomp_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, posit word width.
REQ-002 SHALL have parameter MAX_OUT, default 4, maximum operations in flight inside the unit (range 1..7).
REQ-003 SHALL have ports (name  direction  width  meaning):
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  abort all held and in-flight work.
- req_valid_i  in  2  per-requester request valid.
- req_ready_o  out  2  per-requester request accept.
- req_operands_i  in  2x2xWIDTH  per-requester operand pair.
- req_op_i  in  2x4  per-requester operation code.
- req_op_mod_i  in  2  per-requester operation modifier.
- req_rnd_i  in  2x3  per-requester rounding mode.
- unit_valid_o  out  1  issue valid to the noncomp unit.
- unit_ready_i  in  1  unit input ready.
- unit_operands_o  out  2xWIDTH  issued operands.
- unit_op_o  out  4  issued operation code.
- unit_op_mod_o  out  1  issued modifier.
- unit_rnd_o  out  3  issued rounding mode.
- unit_tag_o  out  1  issued requester ID.
- unit_flush_o  out  1  flush forwarded to the unit.
- unit_out_valid_i  in  1  unit result valid.
- unit_out_ready_o  out  1  unit result accept.
- unit_result_i  in  WIDTH  unit result.
- unit_status_i  in  5  unit status flags.
- unit_tag_i  in  1  result requester ID.
- rsp_valid_o  out  2  per-requester response valid.
- rsp_ready_i  in  2  per-requester response accept.
- rsp_result_o  out  WIDTH  shared response result.
- rsp_status_o  out  5  shared response status.
- busy_o  out  1  held or in-flight work exists.

Function
REQ-004 SHALL hold exactly one accepted request in an issue slot (slot_valid, slot_tag, payload).
REQ-005 SHALL implement the FSM states:
- EMPTY: slot empty.
- HELD: slot full and cnt<MAX_OUT.
- STALL: slot full and cnt==MAX_OUT.
REQ-006 SHALL make transitions EMPTY->HELD on accept; HELD->EMPTY on issue without a same-cycle accept; HELD->STALL when cnt reaches MAX_OUT; STALL->HELD when cnt drops below MAX_OUT.
REQ-007 SHALL allow a grant only when not flushing, and either the slot is empty or the slot issues in the same cycle.
REQ-008 SHALL assert req_ready_o only for the granted requester.
REQ-009 SHALL arbitrate round-robin: when both requesters are valid, grant the requester not granted last; a sole valid requester always wins; last_grant updates only on an accept.
REQ-010 SHALL drive unit_valid_o = slot_valid && cnt<MAX_OUT && !flush_i.
REQ-011 SHALL drive unit_tag_o = slot_tag and unit payload from the slot.
REQ-012 SHALL have an accept-to-issue latency of one cycle (request accepted in cycle N, unit_valid_o high in N+1).
REQ-013 SHALL hold the slot payload stable while unit_valid_o && !unit_ready_i.
REQ-014 SHALL update the cnt counter (3 bits) as follows: +1 on an unit_valid_o&&unit_ready_i issue; -1 on an unit_out_valid_i&&unit_out_ready_o retire; unchanged when both occur in the same cycle; never exceed MAX_OUT or underflow.
REQ-015 SHALL route responses combinationally with zero latency:
- rsp_valid_o[unit_tag_i] = unit_out_valid_i; the other bit is 0.
- unit_out_ready_o = rsp_ready_i[unit_tag_i].
- rsp_result_o = unit_result_i; rsp_status_o = unit_status_i.
REQ-016 SHALL handle flush_i as follows: unit_flush_o = flush_i; next edge clears slot_valid and cnt, state->EMPTY; no grant and no issue during a flush cycle; last_grant is retained.
REQ-017 SHALL drive busy_o = slot_valid || cnt!=0.

Reset
REQ-018 SHALL, on rst_i, asynchronously set: slot_valid=0, cnt=0, state=EMPTY, last_grant=1 (requester 0 wins the first contention), slot payload=0.
REQ-019 SHALL, during reset, drive req_ready_o=0, unit_valid_o=0, busy_o=0.
REQ-020 SHALL keep rst_i asserted mid-operation from producing spurious issues after release.

Verification
REQ-021 Scenario: both requesters valid continuously, unit_ready_i=1, results returned the next cycle -> grants alternate 0,1,0,1; unit_tag_o sequence 0,1,0,1.
REQ-022 Scenario: single request, SGNJ op, operands 0x4D1EB852/0xC0000000 -> unit_valid_o exactly one cycle after the accept, payload identical to the request.
REQ-023 Scenario: unit_ready_i=1, no results returned, MAX_OUT=4 -> four issues, then STALL with unit_valid_o=0; one retire -> issue resumes next cycle.
REQ-024 Scenario: result with unit_tag_i=1 while rsp_ready_i=2'b01 -> rsp_valid_o=2'b10, unit_out_ready_o=0, cnt unchanged until rsp_ready_i[1]=1.
REQ-025 Scenario: flush_i pulse with the slot full and cnt=3 -> next cycle cnt=0, busy_o=0, no unit_valid_o during the flush cycle.
REQ-026 Scenario: rst_i asserted while state=HELD -> immediate busy_o=0 and unit_valid_o=0; first post-reset contention grants requester 0.

Source files
------------

// File: rtl/posit_noncomp_arb_if.sv
// posit_noncomp_arb_if
// Groups the signals between two requesters, the shared noncomp unit and the
// arbiter that sits between them.
//   slave  : arbiter side (takes requests and unit results, drives issue/responses)
//   master : environment side (requesters plus the noncomp unit)
// Signal names keep the arbiter's point of view: *_i are arbiter inputs, *_o are outputs.
interface posit_noncomp_arb_if #(
    parameter int WIDTH = 32
);
    logic                         flush_i;
    logic [1:0]                   req_valid_i;
    logic [1:0]                   req_ready_o;
    logic [1:0][1:0][WIDTH-1:0]   req_operands_i;
    logic [1:0][3:0]              req_op_i;
    logic [1:0]                   req_op_mod_i;
    logic [1:0][2:0]              req_rnd_i;
    logic                         unit_valid_o;
    logic                         unit_ready_i;
    logic [1:0][WIDTH-1:0]        unit_operands_o;
    logic [3:0]                   unit_op_o;
    logic                         unit_op_mod_o;
    logic [2:0]                   unit_rnd_o;
    logic                         unit_tag_o;
    logic                         unit_flush_o;
    logic                         unit_out_valid_i;
    logic                         unit_out_ready_o;
    logic [WIDTH-1:0]             unit_result_i;
    logic [4:0]                   unit_status_i;
    logic                         unit_tag_i;
    logic [1:0]                   rsp_valid_o;
    logic [1:0]                   rsp_ready_i;
    logic [WIDTH-1:0]             rsp_result_o;
    logic [4:0]                   rsp_status_o;
    logic                         busy_o;

    modport slave (
        input  flush_i, req_valid_i, req_operands_i, req_op_i, req_op_mod_i, req_rnd_i,
               unit_ready_i, unit_out_valid_i, unit_result_i, unit_status_i, unit_tag_i,
               rsp_ready_i,
        output req_ready_o, unit_valid_o, unit_operands_o, unit_op_o, unit_op_mod_o,
               unit_rnd_o, unit_tag_o, unit_flush_o, unit_out_ready_o, rsp_valid_o,
               rsp_result_o, rsp_status_o, busy_o
    );

    modport master (
        output flush_i, req_valid_i, req_operands_i, req_op_i, req_op_mod_i, req_rnd_i,
               unit_ready_i, unit_out_valid_i, unit_result_i, unit_status_i, unit_tag_i,
               rsp_ready_i,
        input  req_ready_o, unit_valid_o, unit_operands_o, unit_op_o, unit_op_mod_o,
               unit_rnd_o, unit_tag_o, unit_flush_o, unit_out_ready_o, rsp_valid_o,
               rsp_result_o, rsp_status_o, busy_o
    );
endinterface

// File: rtl/posit_noncomp_arb.sv
// posit_noncomp_arb
// Two-requester round-robin front end for a shared posit noncomp unit. One
// accepted request is parked in an issue slot and offered to the unit the
// following cycle; at most MAX_OUT operations may be in flight. Results are
// steered back to the requester named by the returned tag with no latency.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : posit_noncomp_arb_if.slave (request, issue, result, response, flush, busy)
//
// state | meaning
// ------+-------------------------------------------
// EMPTY | issue slot empty
// HELD  | slot full, in-flight count below MAX_OUT
// STALL | slot full, in-flight count at MAX_OUT
module posit_noncomp_arb #(
    parameter int WIDTH   = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    posit_noncomp_arb_if.slave       bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HELD  = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);

    state_t                r_state;
    logic [2:0]            r_cnt;
    logic                  r_slot_tag;
    logic                  r_last_grant;
    logic [1:0][WIDTH-1:0] r_operands;
    logic [3:0]            r_op;
    logic                  r_op_mod;
    logic [2:0]            r_rnd;

    logic                  w_slot_valid;
    logic                  w_issue;
    logic                  w_retire;
    logic                  w_can_grant;
    logic                  w_sel;
    logic                  w_accept;
    logic                  w_slot_valid_nxt;
    logic [2:0]            w_cnt_nxt;

    assign w_slot_valid = (r_state != EMPTY);

    // HELD already encodes "slot full and below the in-flight limit".
    assign bus.unit_valid_o    = (r_state == HELD) && !bus.flush_i;
    assign bus.unit_operands_o = r_operands;
    assign bus.unit_op_o       = r_op;
    assign bus.unit_op_mod_o   = r_op_mod;
    assign bus.unit_rnd_o      = r_rnd;
    assign bus.unit_tag_o      = r_slot_tag;
    assign bus.unit_flush_o    = bus.flush_i;

    assign w_issue = bus.unit_valid_o && bus.unit_ready_i;

    // Response path is purely combinational, steered by the returned tag.
    assign bus.rsp_valid_o      = bus.unit_out_valid_i ? (bus.unit_tag_i ? 2'b10 : 2'b01) : 2'b00;
    assign bus.unit_out_ready_o = bus.rsp_ready_i[bus.unit_tag_i];
    assign bus.rsp_result_o     = bus.unit_result_i;
    assign bus.rsp_status_o     = bus.unit_status_i;

    // A stray result with nothing in flight must not wrap the counter.
    assign w_retire = bus.unit_out_valid_i && bus.unit_out_ready_o && (r_cnt != 3'd0);

    // Slot can take a new request when empty or when it drains this cycle.
    assign w_can_grant = !rst_i && !bus.flush_i && (!w_slot_valid || w_issue);

    // Contention goes to whoever did not win last; otherwise the sole valid requester.
    assign w_sel    = (&bus.req_valid_i) ? ~r_last_grant : ~bus.req_valid_i[0];
    assign w_accept = w_can_grant && bus.req_valid_i[w_sel];

    assign bus.req_ready_o = w_accept ? (w_sel ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (bus.flush_i) begin
            w_cnt_nxt = 3'd0;
        end else if (w_issue && !w_retire) begin
            w_cnt_nxt = r_cnt + 3'd1;
        end else if (!w_issue && w_retire) begin
            w_cnt_nxt = r_cnt - 3'd1;
        end
    end

    assign w_slot_valid_nxt = !bus.flush_i && (w_accept || (w_slot_valid && !w_issue));

    assign bus.busy_o = w_slot_valid || (r_cnt != 3'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= EMPTY;
            r_cnt        <= 3'd0;
            r_slot_tag   <= 1'b0;
            r_last_grant <= 1'b1;
            r_operands   <= '0;
            r_op         <= 4'd0;
            r_op_mod     <= 1'b0;
            r_rnd        <= 3'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (!w_slot_valid_nxt) begin
                r_state <= EMPTY;
            end else if (w_cnt_nxt == MAX_CNT) begin
                r_state <= STALL;
            end else begin
                r_state <= HELD;
            end
            if (w_accept) begin
                r_slot_tag   <= w_sel;
                r_last_grant <= w_sel;
                r_operands   <= bus.req_operands_i[w_sel];
                r_op         <= bus.req_op_i[w_sel];
                r_op_mod     <= bus.req_op_mod_i[w_sel];
                r_rnd        <= bus.req_rnd_i[w_sel];
            end
        end
    end
endmodule

// File: tb/tb_posit_noncomp_arb.sv
module tb_posit_noncomp_arb;
    localparam int MAX_OUT = 4;
    localparam logic [3:0] OP_SGNJ = 4'd5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    posit_noncomp_arb_if #(.WIDTH(32)) bus ();

    posit_noncomp_arb #(.WIDTH(32), .MAX_OUT(MAX_OUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- spec-level model, checked every cycle ----------------
    bit                 m_sv   = 1'b0;
    int                 m_cnt  = 0;
    bit                 m_last = 1'b1;
    bit                 m_tag  = 1'b0;
    logic [1:0][31:0]   m_ops  = '0;
    logic [3:0]         m_op   = '0;
    logic               m_mod  = 1'b0;
    logic [2:0]         m_rnd  = '0;

    initial begin
        bit exp_uv, issue, can, win, acc, retire;
        logic [1:0] v, e_ready, e_rspv;
        forever begin
            @(negedge clk);
            #2;
            chk("flush_fwd", 64'(bus.unit_flush_o), 64'(bus.flush_i));
            e_rspv = 2'b00;
            if (bus.unit_out_valid_i) e_rspv[bus.unit_tag_i] = 1'b1;
            chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(e_rspv));
            chk("unit_out_ready", 64'(bus.unit_out_ready_o), 64'(bus.rsp_ready_i[bus.unit_tag_i]));
            chk("rsp_result", 64'(bus.rsp_result_o), 64'(bus.unit_result_i));
            chk("rsp_status", 64'(bus.rsp_status_o), 64'(bus.unit_status_i));
            if (rst) begin
                m_sv = 1'b0; m_cnt = 0; m_last = 1'b1;
                chk("rst_ready", 64'(bus.req_ready_o), 64'(0));
                chk("rst_unit_valid", 64'(bus.unit_valid_o), 64'(0));
                chk("rst_busy", 64'(bus.busy_o), 64'(0));
            end else begin
                v      = bus.req_valid_i;
                exp_uv = m_sv && (m_cnt < MAX_OUT) && !bus.flush_i;
                issue  = exp_uv && bus.unit_ready_i;
                can    = !bus.flush_i && (!m_sv || issue);
                if (v == 2'b11) win = !m_last;
                else            win = v[1];
                acc     = can && v[win];
                e_ready = 2'b00;
                if (acc) e_ready[win] = 1'b1;
                retire  = bus.unit_out_valid_i && bus.rsp_ready_i[bus.unit_tag_i];
                chk("req_ready", 64'(bus.req_ready_o), 64'(e_ready));
                chk("unit_valid", 64'(bus.unit_valid_o), 64'(exp_uv));
                chk("busy", 64'(bus.busy_o), 64'(m_sv || m_cnt != 0));
                if (exp_uv) begin
                    chk("unit_tag", 64'(bus.unit_tag_o), 64'(m_tag));
                    chk("unit_ops", 64'(bus.unit_operands_o), 64'(m_ops));
                    chk("unit_op", 64'(bus.unit_op_o), 64'(m_op));
                    chk("unit_mod", 64'(bus.unit_op_mod_o), 64'(m_mod));
                    chk("unit_rnd", 64'(bus.unit_rnd_o), 64'(m_rnd));
                end
                if (bus.flush_i) begin
                    m_sv = 1'b0; m_cnt = 0;
                end else begin
                    if (issue) m_cnt++;
                    if (retire && m_cnt > 0) m_cnt--;
                    if (acc) begin
                        m_sv = 1'b1; m_tag = win; m_last = win;
                        m_ops = bus.req_operands_i[win]; m_op = bus.req_op_i[win];
                        m_mod = bus.req_op_mod_i[win];   m_rnd = bus.req_rnd_i[win];
                    end else if (issue) begin
                        m_sv = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- fake unit + per-cycle snapshots ----------------
    bit               uq[$];
    bit               g_log[$];
    bit               i_log[$];
    bit               ret_en = 1'b0;
    int               res_cnt = 0;
    logic [1:0]       s_ready, s_rspv;
    logic             s_uv, s_busy, s_uor, s_tag, s_flush, s_mod;
    logic [1:0][31:0] s_ops;
    logic [3:0]       s_op;
    logic [2:0]       s_rnd;

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic cycle();
        bus.unit_out_valid_i = ret_en && (uq.size() > 0);
        bus.unit_tag_i       = (uq.size() > 0) ? uq[0] : 1'b0;
        bus.unit_result_i    = 32'hA500_0000 | 32'(res_cnt);
        bus.unit_status_i    = 5'(res_cnt);
        #3;
        s_ready = bus.req_ready_o;     s_uv   = bus.unit_valid_o;
        s_busy  = bus.busy_o;          s_rspv = bus.rsp_valid_o;
        s_uor   = bus.unit_out_ready_o; s_tag = bus.unit_tag_o;
        s_flush = bus.unit_flush_o;    s_ops  = bus.unit_operands_o;
        s_op    = bus.unit_op_o;       s_mod  = bus.unit_op_mod_o;
        s_rnd   = bus.unit_rnd_o;
        if (s_ready != 2'b00) g_log.push_back(s_ready[1]);
        if (rst || bus.flush_i) begin
            uq.delete();
        end else begin
            if (bus.unit_out_valid_i && s_uor) begin
                void'(uq.pop_front());
                res_cnt++;
            end
            if (s_uv && bus.unit_ready_i) begin
                uq.push_back(s_tag);
                i_log.push_back(s_tag);
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n = 0;
        bus.req_valid_i = 2'b00; bus.unit_ready_i = 1'b1; bus.rsp_ready_i = 2'b11; ret_en = 1'b1;
        do begin
            cycle();
            n++;
        end while (s_busy && n < 30);
        chk(name, 64'(s_busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.flush_i = 1'b0; bus.req_valid_i = 2'b11; bus.unit_ready_i = 1'b1;
        bus.rsp_ready_i = 2'b11; bus.unit_out_valid_i = 1'b0; bus.unit_tag_i = 1'b0;
        bus.unit_result_i = '0; bus.unit_status_i = '0;
        bus.req_operands_i[0] = {32'h1111_0000, 32'h0000_1111};
        bus.req_operands_i[1] = {32'h2222_0000, 32'h0000_2222};
        bus.req_op_i[0] = 4'd1; bus.req_op_i[1] = 4'd2;
        bus.req_op_mod_i = 2'b10;
        bus.req_rnd_i[0] = 3'd1; bus.req_rnd_i[1] = 3'd3;
        #1 rst = 1'b1;
        @(negedge clk);

        // reset with both requesters asking
        repeat (2) cycle();
        chk("reset_ready", 64'(s_ready), 64'(0));
        chk("reset_uv", 64'(s_uv), 64'(0));
        chk("reset_busy", 64'(s_busy), 64'(0));
        bus.req_valid_i = 2'b00;
        rst = 1'b0;
        cycle();

        // continuous contention, results returned next cycle
        g_log.delete(); i_log.delete();
        bus.req_valid_i = 2'b11; ret_en = 1'b1;
        repeat (5) cycle();
        chk("rr_grant_count", 64'(g_log.size()), 64'(5));
        chk("rr_issue_count", 64'(i_log.size()), 64'(4));
        if (g_log.size() >= 4)
            chk("rr_grant_seq", 64'({g_log[0], g_log[1], g_log[2], g_log[3]}), 64'(4'b0101));
        if (i_log.size() >= 4)
            chk("rr_tag_seq", 64'({i_log[0], i_log[1], i_log[2], i_log[3]}), 64'(4'b0101));
        drain("rr_drain");

        // single SGNJ request from requester 1
        bus.req_operands_i[1] = {32'hC000_0000, 32'h4D1E_B852};
        bus.req_op_i[1] = OP_SGNJ; bus.req_rnd_i[1] = 3'd2;
        ret_en = 1'b0; bus.req_valid_i = 2'b10;
        cycle();
        chk("single_accept", 64'(s_ready), 64'(2'b10));
        chk("single_uv_accept_cycle", 64'(s_uv), 64'(0));
        bus.req_valid_i = 2'b00;
        cycle();
        chk("single_uv_next", 64'(s_uv), 64'(1));
        chk("single_tag", 64'(s_tag), 64'(1));
        chk("single_op0", 64'(s_ops[0]), 64'(32'h4D1E_B852));
        chk("single_op1", 64'(s_ops[1]), 64'(32'hC000_0000));
        chk("single_opcode", 64'(s_op), 64'(OP_SGNJ));
        chk("single_mod", 64'(s_mod), 64'(1));
        chk("single_rnd", 64'(s_rnd), 64'(2));
        cycle();
        chk("single_uv_once", 64'(s_uv), 64'(0));
        drain("single_drain");

        // fill to MAX_OUT with no results, then one retire
        i_log.delete();
        ret_en = 1'b0; bus.req_valid_i = 2'b01;
        repeat (8) cycle();
        chk("stall_issues", 64'(i_log.size()), 64'(4));
        chk("stall_uv", 64'(s_uv), 64'(0));
        chk("stall_busy", 64'(s_busy), 64'(1));
        ret_en = 1'b1;
        cycle();
        chk("stall_retire_uor", 64'(s_uor), 64'(1));
        chk("stall_retire_uv", 64'(s_uv), 64'(0));
        ret_en = 1'b0;
        cycle();
        chk("stall_resume_uv", 64'(s_uv), 64'(1));

        // back to a full slot with three in flight, unit not ready
        bus.req_valid_i = 2'b00; bus.unit_ready_i = 1'b0; ret_en = 1'b1;
        cycle();
        ret_en = 1'b0;
        repeat (2) cycle();
        chk("held_uv", 64'(s_uv), 64'(1));
        chk("held_busy", 64'(s_busy), 64'(1));

        // flush pulse
        bus.flush_i = 1'b1; bus.req_valid_i = 2'b11;
        cycle();
        chk("flush_uv", 64'(s_uv), 64'(0));
        chk("flush_no_grant", 64'(s_ready), 64'(0));
        chk("flush_unit_flush", 64'(s_flush), 64'(1));
        bus.flush_i = 1'b0; bus.req_valid_i = 2'b00;
        cycle();
        chk("after_flush_busy", 64'(s_busy), 64'(0));

        // response steering with requester 1 not ready
        bus.unit_ready_i = 1'b1; bus.rsp_ready_i = 2'b01; bus.req_valid_i = 2'b10;
        cycle();
        bus.req_valid_i = 2'b00;
        cycle();
        ret_en = 1'b1;
        cycle();
        chk("steer_rsp_valid", 64'(s_rspv), 64'(2'b10));
        chk("steer_uor_blocked", 64'(s_uor), 64'(0));
        cycle();
        chk("steer_busy_held", 64'(s_busy), 64'(1));
        bus.rsp_ready_i = 2'b11;
        cycle();
        chk("steer_uor", 64'(s_uor), 64'(1));
        cycle();
        chk("steer_done_busy", 64'(s_busy), 64'(0));

        // reset while HELD, last winner was requester 0
        ret_en = 1'b0; bus.unit_ready_i = 1'b0; bus.req_valid_i = 2'b01;
        cycle();
        bus.req_valid_i = 2'b11; rst = 1'b1;
        cycle();
        chk("midrst_busy", 64'(s_busy), 64'(0));
        chk("midrst_uv", 64'(s_uv), 64'(0));
        chk("midrst_ready", 64'(s_ready), 64'(0));
        cycle();
        rst = 1'b0; bus.unit_ready_i = 1'b1;
        cycle();
        chk("postrst_grant", 64'(s_ready), 64'(2'b01));
        drain("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
